// File: rtl/matrix_opp_seq_pkg.sv
// Shared types and helpers for the matrix opposite/scale unit.
// Build option: OPP_SAT_EN selects saturating (defined) or wrapping (undefined) overflow results.
package matrix_opp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_NEG   = 1'b0,
        MODE_SCALE = 1'b1
    } mode_e;

    // Bit offset of element idx inside a packed row of w-bit elements.
    function automatic int elem_lsb(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/matrix_opp_seq_opp_elem.sv
// Single-element negate/scale, purely combinational, with per-element overflow flag.
// Overflow result saturates when OPP_SAT_EN is defined, otherwise wraps to ELEM_W bits.
module opp_elem
    import matrix_opp_seq_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic [ELEM_W-1:0] elem_in,
    input  mode_e             mode,
    input  logic [ELEM_W-1:0] scalar,
    output logic [ELEM_W-1:0] elem_out,
    output logic              elem_ovf
);

    localparam int PW = 2 * ELEM_W;
    localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(ELEM_W));
    localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(ELEM_W));

    logic signed [PW-1:0] in_ext;
    logic signed [PW-1:0] sc_ext;
    logic signed [PW-1:0] res;

    // Both operations are evaluated at double width so one range check covers them.
    assign in_ext   = {{ELEM_W{elem_in[ELEM_W-1]}}, elem_in};
    assign sc_ext   = {{ELEM_W{scalar[ELEM_W-1]}}, scalar};
    assign res      = (mode == MODE_SCALE) ? (in_ext * sc_ext) : -in_ext;
    assign elem_ovf = (res > P_MAX) || (res < P_MIN);

`ifdef OPP_SAT_EN
    assign elem_out = elem_ovf ? (res[PW-1] ? P_MIN[ELEM_W-1:0] : P_MAX[ELEM_W-1:0])
                               : res[ELEM_W-1:0];
`else
    assign elem_out = res[ELEM_W-1:0];
`endif

endmodule

// File: rtl/matrix_opp_seq.sv
// Row-sequential N x N matrix negate/scale with one registered output row and done pulse.
// Latency 1 cycle; row_in_ready drops while the output row is stalled. Option: OPP_SAT_EN.
module matrix_opp_seq
    import matrix_opp_seq_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int N      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [ELEM_W-1:0]   scalar,
    input  logic [N*ELEM_W-1:0] row_in,
    input  logic                row_in_valid,
    output logic                row_in_ready,
    output logic [N*ELEM_W-1:0] row_out,
    output logic                row_out_valid,
    input  logic                row_out_ready,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int              CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] ROWS = CNT_W'(N);

    state_e              state;
    state_e              state_nxt;
    logic [CNT_W-1:0]    cnt;
    mode_e               mode_q;
    logic [ELEM_W-1:0]   scalar_q;
    logic [N*ELEM_W-1:0] row_res;
    logic [N-1:0]        elem_ovf;
    logic                start_acc;
    logic                in_hs;
    logic                out_hs;

    for (genvar i = 0; i < N; i++) begin : g_elem
        opp_elem #(.ELEM_W(ELEM_W)) u_elem (
            .elem_in  (row_in[elem_lsb(i, ELEM_W) +: ELEM_W]),
            .mode     (mode_q),
            .scalar   (scalar_q),
            .elem_out (row_res[elem_lsb(i, ELEM_W) +: ELEM_W]),
            .elem_ovf (elem_ovf[i])
        );
    end

    assign start_acc    = (state == IDLE) && start;
    assign row_in_ready = (state == RUN) && (cnt != ROWS) && (!row_out_valid || row_out_ready);
    assign in_hs        = row_in_valid && row_in_ready;
    assign out_hs       = row_out_valid && row_out_ready;
    assign busy         = (state == RUN);
    assign done         = (state == FIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            // Once all rows are in, ready is low, so an output handshake empties the register.
            RUN:     if ((cnt == ROWS) && out_hs) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            mode_q        <= MODE_NEG;
            scalar_q      <= '0;
            row_out       <= '0;
            row_out_valid <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            if (start_acc) begin
                mode_q   <= mode_e'(mode);
                scalar_q <= scalar;
                cnt      <= '0;
                ovf      <= 1'b0;
            end
            if (in_hs) begin
                row_out       <= row_res;
                row_out_valid <= 1'b1;
                cnt           <= cnt + 1'b1;
                ovf           <= ovf | (|elem_ovf);
            end else if (out_hs) begin
                row_out_valid <= 1'b0;
            end
        end
    end

endmodule
